// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
// Requester-side bus of the ALU arbiter: four packed request channels plus
// the shared response signals.
//   req       4   request per requester
//   op_in     12  opcodes, requester i on [3i+2:3i]
//   a_in      24  operand A, requester i on [6i+5:6i]
//   b_in      24  operand B, same packing as a_in
//   ack       4   one-hot acknowledge pulse
//   rsp_data  6   result, valid in the ack cycle
//   grant_id  2   current or last granted requester
//   busy      1   arbiter is executing or responding
//
// Handshake: a requester raises req[i] with its op/a/b stable and keeps it
// high until it sees ack[i]. ack[i] is a single-cycle pulse, and rsp_data is
// valid in that same cycle. The requester drops req[i] on the edge where it
// samples ack[i]. Operands are captured only on the grant edge.
interface alu_arbiter_if;
  logic [3:0]  req;
  logic [11:0] op_in;
  logic [23:0] a_in;
  logic [23:0] b_in;
  logic [3:0]  ack;
  logic [5:0]  rsp_data;
  logic [1:0]  grant_id;
  logic        busy;

  modport slave (
    input  req, op_in, a_in, b_in,
    output ack, rsp_data, grant_id, busy
  );

  modport master (
    output req, op_in, a_in, b_in,
    input  ack, rsp_data, grant_id, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Round-robin arbiter and sequencer that shares one 6-bit ALU between four
// requesters. The winner's opcode and operands are latched at grant, then
// held on the ALU for ALU_LAT cycles. The result is captured and returned
// with a one-cycle ack.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   bus          requester bus (alu_arbiter_if.slave)
//   alu_a/alu_b  operands to the ALU (registered)
//   alu_opcode   result multiplexer select (registered)
//   alu_result   result multiplexer output
//   state_dbg    current FSM state (IDLE=0, EXEC=1, RESP=2)
module alu_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus,
  output logic [5:0]    alu_a,
  output logic [5:0]    alu_b,
  output logic [2:0]    alu_opcode,
  input  logic [5:0]    alu_result,
  output logic [1:0]    state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

  logic [1:0] state;
  logic [1:0] ptr;
  logic [3:0] cnt;

  logic       win_found;
  logic [1:0] win_id;
  logic [1:0] idx;

  // Round-robin pick: scan from the lowest priority (ptr+3) up to ptr.
  // The last hit therefore belongs to the highest-priority requester.
  always_comb begin
    win_found = 1'b0;
    win_id    = ptr;
    idx       = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (bus.req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ptr          <= '0;
      cnt          <= '0;
      bus.ack      <= '0;
      bus.rsp_data <= '0;
      bus.grant_id <= '0;
      bus.busy     <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_opcode   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            alu_opcode   <= bus.op_in[3*win_id +: 3];
            alu_a        <= bus.a_in[6*win_id +: 6];
            alu_b        <= bus.b_in[6*win_id +: 6];
            bus.grant_id <= win_id;
            cnt          <= CNT_LOAD;
            bus.busy     <= 1'b1;
            state        <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // alu_result has settled on the operands held since the grant.
            bus.rsp_data <= alu_result;
            bus.ack      <= 4'b0001 << bus.grant_id;
            state        <= S_RESP;
          end
        end
        S_RESP: begin
          // The pointer moves past the requester just served. The next
          // arbitration happens in the following IDLE cycle.
          bus.ack  <= '0;
          ptr      <= bus.grant_id + 2'd1;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Two instances: ALU_LAT=1 for the single-op case, ALU_LAT=2 for the rest.
  alu_arbiter_if rif1 ();
  alu_arbiter_if rif2 ();

  logic [5:0] alu_a1, alu_b1, alu_res1;
  logic [2:0] alu_op1;
  logic [1:0] st1;
  logic [5:0] alu_a2, alu_b2, alu_res2;
  logic [2:0] alu_op2;
  logic [1:0] st2;

  // Bench ALU: an 8-way result mux with 6-bit wraparound.
  function automatic logic [5:0] alu_fn(input logic [2:0] op, input logic [5:0] a,
                                        input logic [5:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b011:  return a - b;
      3'b100:  return a ^ b;
      3'b101:  return ~a;
      3'b110:  return a;
      default: return b;
    endcase
  endfunction

  assign alu_res1 = alu_fn(alu_op1, alu_a1, alu_b1);
  assign alu_res2 = alu_fn(alu_op2, alu_a2, alu_b2);

  alu_arbiter #(.ALU_LAT(1)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (rif1.slave),
    .alu_a      (alu_a1),
    .alu_b      (alu_b1),
    .alu_opcode (alu_op1),
    .alu_result (alu_res1),
    .state_dbg  (st1)
  );

  alu_arbiter #(.ALU_LAT(2)) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (rif2.slave),
    .alu_a      (alu_a2),
    .alu_b      (alu_b2),
    .alu_opcode (alu_op2),
    .alu_result (alu_res2),
    .state_dbg  (st2)
  );

  // ---------------- scoreboard ----------------
  logic [5:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op2(input int i, input logic [2:0] op, input logic [5:0] a,
                         input logic [5:0] b);
    rif2.op_in[3*i +: 3] = op;
    rif2.a_in[6*i +: 6]  = a;
    rif2.b_in[6*i +: 6]  = b;
  endtask

  task automatic chk_zero2(input string tag);
    chk({tag, "_ack"},   32'(rif2.ack), 32'h0);
    chk({tag, "_rsp"},   32'(rif2.rsp_data), 32'h0);
    chk({tag, "_gid"},   32'(rif2.grant_id), 32'h0);
    chk({tag, "_busy"},  32'(rif2.busy), 32'h0);
    chk({tag, "_alu_a"}, 32'(alu_a2), 32'h0);
    chk({tag, "_alu_b"}, 32'(alu_b2), 32'h0);
    chk({tag, "_alu_op"}, 32'(alu_op2), 32'h0);
    chk({tag, "_state"}, 32'(st2), 32'h0);
  endtask

  // Wait (bounded) for an ack on instance 2, then check latency, grant,
  // and data against the scoreboard. The acked requester drops its req.
  task automatic expect_ack(input string tag, input int exp_lat, input int exp_gid);
    int          cyc;
    logic [3:0]  a;
    logic [5:0]  exp_d;
    cyc = 0;
    a   = '0;
    while (cyc < 20) begin
      tick();
      cyc++;
      if (rif2.ack != 4'b0) begin
        a = rif2.ack;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(a != 4'b0), 32'h1);
    chk({tag, "_lat"},  32'(cyc), 32'(exp_lat));
    chk({tag, "_ack"},  32'(a), 32'(4'b0001 << exp_gid));
    chk({tag, "_gid"},  32'(rif2.grant_id), 32'(exp_gid));
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h0;
    chk({tag, "_rsp"},  32'(rif2.rsp_data), 32'(exp_d));
    rif2.req[exp_gid] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int extra;
    rst_n     = 1'b0;
    rif1.req  = '0; rif1.op_in = '0; rif1.a_in = '0; rif1.b_in = '0;
    rif2.req  = '0; rif2.op_in = '0; rif2.a_in = '0; rif2.b_in = '0;
    tick();
    tick();
    rst_n = 1'b1;
    chk_zero2("reset");

    // Single op, ALU_LAT=1: 5 + 3 = 8.
    rif1.op_in[2:0] = 3'b010;
    rif1.a_in[5:0]  = 6'd5;
    rif1.b_in[5:0]  = 6'd3;
    rif1.req        = 4'b0001;
    tick();
    chk("single_op",   32'(alu_op1), 32'h2);
    chk("single_a",    32'(alu_a1), 32'd5);
    chk("single_b",    32'(alu_b1), 32'd3);
    chk("single_busy", 32'(rif1.busy), 32'h1);
    chk("single_ack0", 32'(rif1.ack), 32'h0);
    tick();
    chk("single_ack",  32'(rif1.ack), 32'b0001);
    chk("single_rsp",  32'(rif1.rsp_data), 32'd8);
    chk("single_gid",  32'(rif1.grant_id), 32'd0);
    rif1.req = '0;
    tick();
    chk("single_ackclr", 32'(rif1.ack), 32'h0);
    chk("single_busy0",  32'(rif1.busy), 32'h0);
    chk("single_hold_a", 32'(alu_a1), 32'd5);

    // Contention on instance 2 (ptr=0 since reset): grants 0,1,2,3.
    set_op2(0, 3'b010, 6'd5,  6'd3);    // 8
    set_op2(1, 3'b011, 6'd20, 6'd6);    // 14
    set_op2(2, 3'b100, 6'h2A, 6'h0F);   // 0x25
    set_op2(3, 3'b000, 6'h3C, 6'h0F);   // 0x0C
    exp_q.push_back(6'd8);
    exp_q.push_back(6'd14);
    exp_q.push_back(6'h25);
    exp_q.push_back(6'h0C);
    rif2.req = 4'b1111;
    expect_ack("cont0", 3, 0);
    expect_ack("cont1", 4, 1);
    expect_ack("cont2", 4, 2);
    expect_ack("cont3", 4, 3);
    tick();
    chk("cont_idle", 32'(st2), 32'h0);

    // Serve requester 2 so that ptr becomes 3 before the abort.
    set_op2(2, 3'b010, 6'd9, 6'd9);     // 18
    set_op2(3, 3'b010, 6'd1, 6'd1);     // 2
    exp_q.push_back(6'd18);
    rif2.req = 4'b0100;
    expect_ack("pre_abort", 3, 2);
    tick();

    // Abort: grant to requester 3, reset asynchronously in EXEC.
    rif2.req = 4'b1000;
    tick();
    chk("abort_gid",  32'(rif2.grant_id), 32'd3);
    chk("abort_busy", 32'(rif2.busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero2("async_rst");
    rif2.req = '0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_zero2("post_rst");
    end

    // ptr is back at 0: req=1100 serves 2 first, then 3.
    exp_q.push_back(6'd18);
    exp_q.push_back(6'd2);
    rif2.req = 4'b1100;
    expect_ack("after_abort2", 3, 2);
    expect_ack("after_abort3", 4, 3);
    tick();

    // Operand isolation: change a_in and drop req during EXEC.
    set_op2(1, 3'b011, 6'd10, 6'd7);    // 3
    exp_q.push_back(6'd3);
    rif2.req = 4'b0010;
    tick();
    rif2.a_in[11:6] = 6'd60;
    rif2.req        = 4'b0000;
    expect_ack("isolate", 2, 1);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rif2.ack != 4'b0) extra++;
    end
    chk("isolate_once", 32'(extra), 32'd0);

    // Fairness: req[0] and req[2] re-raised the cycle after each ack.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_op2(0, 3'b001, 6'h30, 6'h03);   // 0x33
    set_op2(2, 3'b010, 6'd40, 6'd30);   // 70 wraps to 6
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(6'h33);
      exp_q.push_back(6'd6);
    end
    rif2.req = 4'b0101;
    expect_ack("fair0", 3, 0);
    for (int i = 1; i < 6; i++) begin
      tick();
      rif2.req[(i % 2 == 1) ? 0 : 2] = 1'b1;
      expect_ack($sformatf("fair%0d", i), 3, (i % 2 == 1) ? 2 : 0);
    end
    rif2.req = '0;
    tick();
    chk("fair_q_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single 6-bit ALU datapath (operand inputs plus the 3-bit opcode that drives the 8-way result multiplexer) between four requesters. It latches the winning request's opcode and operands, drives them to the ALU for a fixed number of cycles, captures the multiplexer result, and returns it to the requester with a one-cycle acknowledge. It sits between the requesting control blocks and the ALU/result-mux pair.

## Interface
- ALU_LAT, default 1: number of EXEC cycles the ALU inputs are held before the result is sampled; legal range 1..15.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  4  request per requester i; held high until ack[i].
- op_in  in  12  opcodes, requester i on [3i+2:3i].
- a_in  in  24  operand A, requester i on [6i+5:6i].
- b_in  in  24  operand B, same packing as a_in.
- ack  out  4  one-hot, one-cycle pulse; rsp_data valid in the same cycle.
- rsp_data  out  6  captured ALU result.
- grant_id  out  2  index of the current or last granted requester.
- busy  out  1  high in EXEC and RESP.
- alu_a  out  6  operand A to the ALU.
- alu_b  out  6  operand B to the ALU.
- alu_opcode  out  3  select for the ALU result multiplexer.
- alu_result  in  6  output of the result multiplexer.

## Operation
- States: IDLE, EXEC, RESP. Every output is a register.
- IDLE: if req != 0, pick the winner by round-robin. Priority order is ptr, ptr+1, ptr+2, ptr+3, all mod 4. On the clock edge:
  - latch op_in/a_in/b_in of the winner into alu_opcode/alu_a/alu_b;
  - set grant_id to the winner;
  - load cnt = ALU_LAT-1;
  - go to EXEC.
- IDLE with req == 0: stay in IDLE; all outputs hold.
- EXEC: alu_* hold their values. If cnt != 0, decrement cnt. If cnt == 0, capture alu_result into rsp_data, set ack[grant_id]=1, go to RESP.
- RESP (exactly one cycle):
  - clear ack to 0;
  - set ptr = grant_id+1 mod 4;
  - go to IDLE.
- The arbiter samples operands only at grant. Changes to op_in/a_in/b_in after the grant are ignored.
- If a requester drops req after the grant, the operation still completes and ack still pulses. A requester must not do this.
- alu_a/alu_b/alu_opcode/rsp_data/grant_id keep their last values in IDLE. They do not return to zero.
- RESP never arbitrates. The earliest back-to-back grant is the IDLE cycle after RESP.
- A requester drops req on the edge where it samples ack, so req is already low when IDLE next evaluates it.
- Simultaneous requests: exactly one grant per transaction. Losing requests stay pending and are not lost.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE, ptr = 0, cnt = 0;
  - ack = 0, rsp_data = 0, grant_id = 0, busy = 0;
  - alu_a = alu_b = 0, alu_opcode = 0.
- Reset mid-operation aborts the transaction immediately. No ack is issued, and all outputs go to their reset values.
- Latency: req first high in IDLE cycle 0 gives EXEC in cycles 1..ALU_LAT and RESP/ack in cycle ALU_LAT+1.
- alu_result is sampled at the end of the last EXEC cycle.
- Throughput: one operation per ALU_LAT+2 cycles under continuous demand.
- busy rises at the edge leaving IDLE and falls at the edge leaving RESP.

## Test plan
- Reset: hold rst_n low mid-run → all outputs 0 immediately, asynchronously. After release with req=0, outputs stay 0 and state stays IDLE.
- Single op: ALU_LAT=1, bench ALU computes a+b for opcode 010. Drive req=0001, op=010, a=5, b=3 at cycle 0 → alu_opcode=010, alu_a=5, alu_b=3 in cycle 1. In cycle 2: ack=0001, rsp_data=8, grant_id=0.
- Contention: req=1111 from reset with ALU_LAT=2, each requester dropping on its ack → grants in order 0,1,2,3. ack pulses at cycles 3, 7, 11, 15.
- Fairness: req[0] and req[2] held continuously (re-raised the cycle after each ack) → grant sequence 0,2,0,2,… with no starvation.
- Operand isolation: after the grant, change a_in of the winner and drop its req during EXEC → rsp_data uses the latched operands and ack still pulses once.
- Abort: assert rst_n low during EXEC of a grant to requester 3 → no ack. After release, a req=1000 is served normally with ptr=0 priority order.
